// File: rtl/bell_judge_pkg.sv
// Shared definitions for the two-player card game datapath: card field
// widths, the "no card" color, judge FSM states and player indices.
package bell_judge_pkg;

  localparam int COLOR_W = 2;
  localparam int NUM_W   = 3;

  localparam logic [COLOR_W-1:0] COLOR_NONE = '0;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    LOCK = 2'd2,
    OVER = 2'd3
  } state_t;

endpackage

// File: rtl/bell_judge_card_match.sv
// card_match: decides whether the two face-up cards make a correct ring.
// Same nonzero color: numbers must add to TARGET_SUM. Different colors:
// any present card showing TARGET_SUM on its own. No cards: never correct.
module card_match
  import bell_judge_pkg::*;
#(
  parameter int TARGET_SUM = 5
) (
  input  logic [COLOR_W-1:0] color1,
  input  logic [NUM_W-1:0]   number1,
  input  logic [COLOR_W-1:0] color2,
  input  logic [NUM_W-1:0]   number2,
  output logic               ok
);

  // One extra bit so the pair sum cannot wrap.
  localparam logic [NUM_W:0] TGT = (NUM_W+1)'(TARGET_SUM);

  logic [NUM_W:0] sum;
  assign sum = {1'b0, number1} + {1'b0, number2};

  // Apply the ring rule to the current pair.
  always_comb begin
    ok = 1'b0;
    if (color1 == COLOR_NONE && color2 == COLOR_NONE)
      ok = 1'b0;
    else if (color1 == color2)
      ok = (sum == TGT);
    else
      ok = (color1 != COLOR_NONE && {1'b0, number1} == TGT) ||
           (color2 != COLOR_NONE && {1'b0, number2} == TGT);
  end

endmodule

// File: rtl/bell_judge.sv
// bell_judge: latches both face-up cards, edge-detects the two bells,
// judges each ring, keeps scores, holds a post-ring lockout and declares
// the winner. Optional macro BELL_TIE_ROUND_ROBIN_EN alternates the winner
// of simultaneous presses; without it player 1 always wins ties.
module bell_judge
  import bell_judge_pkg::*;
#(
  parameter int TARGET_SUM  = 5,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4,
  parameter int LOCK_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               card_valid,
  input  logic [COLOR_W-1:0] card1_color,
  input  logic [NUM_W-1:0]   card1_number,
  input  logic [COLOR_W-1:0] card2_color,
  input  logic [NUM_W-1:0]   card2_number,
  input  logic               bell1,
  input  logic               bell2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               result_valid,
  output logic               result_ok,
  output logic               result_player,
  output logic               lockout,
  output logic               game_over,
  output logic               winner
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t             state, state_nxt;
  logic [COLOR_W-1:0] c1_q, c2_q;
  logic [NUM_W-1:0]   n1_q, n2_q;
  logic               bell1_q, bell2_q;
  logic [CNT_W-1:0]   lock_cnt;
  logic               press1, press2, judge, ring_ok, ringer, score_hit;

  assign press1    = bell1 & ~bell1_q;
  assign press2    = bell2 & ~bell2_q;
  assign judge     = (state == PLAY) && (press1 || press2);
  assign score_hit = (score1 == WIN) || (score2 == WIN);
  assign lockout   = (state == LOCK);

`ifdef BELL_TIE_ROUND_ROBIN_EN
  // Pointer names the player who wins the next tie; it flips to the loser.
  logic tie_ptr;

  // Pick the ringer: single press wins outright, ties go to the pointer.
  always_comb begin
    ringer = press1 ? PLAYER1 : PLAYER2;
    if (press1 && press2) ringer = tie_ptr;
  end

  // Advance the tie pointer after every judged tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          tie_ptr <= PLAYER1;
    else if (judge && press1 && press2) tie_ptr <= ~ringer;
  end
`else
  // Pick the ringer: player 1 takes any tie.
  always_comb begin
    ringer = press1 ? PLAYER1 : PLAYER2;
  end
`endif

  // Judged against the cards held before this edge's capture.
  card_match #(.TARGET_SUM(TARGET_SUM)) u_match (
    .color1 (c1_q),
    .number1(n1_q),
    .color2 (c2_q),
    .number2(n2_q),
    .ok     (ring_ok)
  );

  // Saturating score step for the ringer.
  function automatic logic [SCORE_W-1:0] step(input logic [SCORE_W-1:0] s,
                                              input logic up);
    if (up)            return s + 1'b1;
    else if (s != '0)  return s - 1'b1;
    else               return s;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: wake on first card, lock after a ring, end once a score wins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (card_valid) state_nxt = PLAY;
      PLAY: if (judge)      state_nxt = LOCK;
      LOCK: if (lock_cnt == '0) state_nxt = score_hit ? OVER : PLAY;
      OVER: state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  // Lockout counter, loaded on the judging edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                lock_cnt <= '0;
    else if (judge)                          lock_cnt <= CNT_LOAD;
    else if (state == LOCK && lock_cnt != '0) lock_cnt <= lock_cnt - 1'b1;
  end

  // Bell history for edge detection; tracks even while bells are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bell1_q <= 1'b0;
      bell2_q <= 1'b0;
    end else begin
      bell1_q <= bell1;
      bell2_q <= bell2;
    end
  end

  // Card latch: a correct ring clears the table and beats a new card.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c1_q <= COLOR_NONE; n1_q <= '0;
      c2_q <= COLOR_NONE; n2_q <= '0;
    end else if (judge && ring_ok) begin
      c1_q <= COLOR_NONE; n1_q <= '0;
      c2_q <= COLOR_NONE; n2_q <= '0;
    end else if (card_valid && state != OVER) begin
      c1_q <= card1_color; n1_q <= card1_number;
      c2_q <= card2_color; n2_q <= card2_number;
    end
  end

  // Scores and the one-cycle result report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score1        <= '0;
      score2        <= '0;
      result_valid  <= 1'b0;
      result_ok     <= 1'b0;
      result_player <= 1'b0;
    end else begin
      result_valid <= judge;
      if (judge) begin
        result_ok     <= ring_ok;
        result_player <= ringer;
        if (ringer == PLAYER1) score1 <= step(score1, ring_ok);
        else                   score2 <= step(score2, ring_ok);
      end
    end
  end

  // Sticky game-over, set the edge after a score reaches WIN_SCORE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (!game_over && score_hit) begin
      game_over <= 1'b1;
      winner    <= (score2 == WIN) ? PLAYER2 : PLAYER1;
    end
  end

endmodule

// File: tb/tb_bell_judge.sv
// Randomized and directed bench for bell_judge with a behavioural model
// of the game rules; outputs are checked every cycle after the clock edge.
module tb_bell_judge;

  localparam int TARGET = 5;
  localparam int WIN    = 7;
  localparam int SW     = 4;
  localparam int LOCK   = 8;

  logic          clk, rst, card_valid, bell1, bell2;
  logic [1:0]    card1_color, card2_color;
  logic [2:0]    card1_number, card2_number;
  logic [SW-1:0] score1, score2;
  logic          result_valid, result_ok, result_player, lockout, game_over, winner;

  bell_judge #(.TARGET_SUM(TARGET), .WIN_SCORE(WIN), .SCORE_W(SW),
               .LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst), .card_valid(card_valid),
    .card1_color(card1_color), .card1_number(card1_number),
    .card2_color(card2_color), .card2_number(card2_number),
    .bell1(bell1), .bell2(bell2), .score1(score1), .score2(score2),
    .result_valid(result_valid), .result_ok(result_ok),
    .result_player(result_player), .lockout(lockout),
    .game_over(game_over), .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rv_cnt = 0;

  // Behavioural game model
  int m_s1, m_s2, m_lock, m_c1, m_n1, m_c2, m_n2;
  bit m_rv, m_ok, m_pl, m_go, m_win, m_started, m_over, m_pb1, m_pb2, m_tie;

  function automatic bit rule_ok(int c1, int n1, int c2, int n2);
    if (c1 == 0 && c2 == 0) return 1'b0;
    if (c1 == c2) return (n1 + n2) == TARGET;
    return (c1 != 0 && n1 == TARGET) || (c2 != 0 && n2 == TARGET);
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lock = 0;
    m_c1 = 0; m_n1 = 0; m_c2 = 0; m_n2 = 0;
    m_rv = 0; m_ok = 0; m_pl = 0; m_go = 0; m_win = 0;
    m_started = 0; m_over = 0; m_pb1 = 0; m_pb2 = 0; m_tie = 0;
  endtask

  task automatic latch();
    m_c1 = card1_color; m_n1 = card1_number;
    m_c2 = card2_color; m_n2 = card2_number;
  endtask

  task automatic model_step();
    bit p1, p2, ok, who;
    p1 = bell1 && !m_pb1;
    p2 = bell2 && !m_pb2;
    m_pb1 = bell1; m_pb2 = bell2;
    m_rv = 0;
    if (!m_go && (m_s1 == WIN || m_s2 == WIN)) begin
      m_go = 1; m_win = (m_s2 == WIN);
    end
    if (m_over) begin
      // frozen
    end else if (!m_started) begin
      if (card_valid) begin m_started = 1; latch(); end
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0 && (m_s1 == WIN || m_s2 == WIN)) m_over = 1;
      if (card_valid) latch();
    end else if (p1 || p2) begin
      if (p1 && p2) begin
`ifdef BELL_TIE_ROUND_ROBIN_EN
        who = m_tie;
        m_tie = !who;
`else
        who = 0;
`endif
      end else begin
        who = p1 ? 1'b0 : 1'b1;
      end
      ok = rule_ok(m_c1, m_n1, m_c2, m_n2);
      if (who == 0) m_s1 = ok ? m_s1 + 1 : (m_s1 > 0 ? m_s1 - 1 : 0);
      else          m_s2 = ok ? m_s2 + 1 : (m_s2 > 0 ? m_s2 - 1 : 0);
      m_rv = 1; m_ok = ok; m_pl = who; m_lock = LOCK;
      if (ok) begin m_c1 = 0; m_n1 = 0; m_c2 = 0; m_n2 = 0; end
      else if (card_valid) latch();
    end else if (card_valid) begin
      latch();
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    cmp("score1", 32'(score1), m_s1);
    cmp("score2", 32'(score2), m_s2);
    cmp("result_valid", 32'(result_valid), 32'(m_rv));
    cmp("lockout", 32'(lockout), 32'(m_lock > 0));
    cmp("game_over", 32'(game_over), 32'(m_go));
    if (m_rv) begin
      cmp("result_ok", 32'(result_ok), 32'(m_ok));
      cmp("result_player", 32'(result_player), 32'(m_pl));
    end
    if (m_go) cmp("winner", 32'(winner), 32'(m_win));
    if (result_valid === 1'b1) rv_cnt++;
  endtask

  // One clock: model follows the edge, check after it, then drive next inputs.
  task automatic tick(input bit cv, input int a_c, input int a_n,
                      input int b_c, input int b_n, input bit b1, input bit b2);
    @(posedge clk);
    if (rst) model_step(); else model_reset();
    @(negedge clk);
    if (rst) compare_all();
    card_valid = cv;
    card1_color = 2'(a_c); card1_number = 3'(a_n);
    card2_color = 2'(b_c); card2_number = 3'(b_n);
    bell1 = b1; bell2 = b2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic areset();
    @(posedge clk);
    model_step();
    #2 rst = 1'b0;
    model_reset();
    #1;
    cmp("rst_score1", 32'(score1), 0);
    cmp("rst_score2", 32'(score2), 0);
    cmp("rst_result_valid", 32'(result_valid), 0);
    cmp("rst_lockout", 32'(lockout), 0);
    cmp("rst_game_over", 32'(game_over), 0);
    cmp("rst_winner", 32'(winner), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; card_valid = 0; bell1 = 0; bell2 = 0;
    card1_color = 0; card1_number = 0; card2_color = 0; card2_number = 0;
    model_reset();
    idle(3);
    cmp("reset_score1", 32'(score1), 0);
    cmp("reset_result_valid", 32'(result_valid), 0);
    cmp("reset_lockout", 32'(lockout), 0);
    cmp("reset_game_over", 32'(game_over), 0);
    rst = 1'b1;

    // Bells in IDLE are ignored
    tick(0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // First card: same color, 2+3 correct; player 1 rings
    tick(1, 1, 2, 1, 3, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    cmp("pin_first_valid", 32'(result_valid), 1);
    cmp("pin_first_ok", 32'(result_ok), 1);
    cmp("pin_first_player", 32'(result_player), 0);
    cmp("pin_first_score1", 32'(score1), 1);
    cmp("pin_model_score1", m_s1, 1);
    rv_cnt = 0;
    idle(LOCK);
    cmp("pin_lock_len_quiet", rv_cnt, 0);

    // Wrong ring by player 2 at score 0 saturates; correct then wrong
    tick(1, 2, 4, 3, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    cmp("pin_wrong_ok", 32'(result_ok), 0);
    cmp("pin_sat_score2", 32'(score2), 0);
    idle(LOCK + 1);
    tick(1, 2, 5, 3, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    cmp("pin_p2_score", 32'(score2), 1);
    idle(LOCK + 1);
    tick(1, 2, 4, 3, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    cmp("pin_p2_back_to_0", 32'(score2), 0);
    idle(LOCK + 1);

    // Held bell1 through lockout and beyond; bell2 press inside lockout
    tick(1, 1, 5, 2, 2, 0, 0);
    rv_cnt = 0;
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 0, 1, 0);
    cmp("pin_held_one_result", rv_cnt, 1);
    idle(2);

    // Ties
    tick(1, 1, 1, 1, 4, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    cmp("pin_tie1_player", 32'(result_player), 0);
    idle(LOCK + 1);
    tick(1, 1, 1, 1, 4, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 0, 0);
`ifdef BELL_TIE_ROUND_ROBIN_EN
    cmp("pin_tie2_player", 32'(result_player), 1);
`else
    cmp("pin_tie2_player", 32'(result_player), 0);
`endif
    idle(LOCK + 1);

    // card_valid on a correct-ring edge is dropped
    tick(1, 3, 2, 3, 3, 0, 0);
    tick(1, 1, 1, 1, 4, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    cmp("pin_clear_ok", 32'(result_ok), 1);
    idle(LOCK + 1);
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    cmp("pin_after_clear_valid", 32'(result_valid), 1);
    cmp("pin_after_clear_ok", 32'(result_ok), 0);
    idle(LOCK + 1);

    // Randomized play with occasional async resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) areset();
      tick($urandom_range(0, 3) == 0,
           $urandom_range(0, 3), $urandom_range(0, 5),
           $urandom_range(0, 3), $urandom_range(0, 5),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    // Player 1 wins with seven correct rings
    areset();
    for (int r = 0; r < WIN; r++) begin
      tick(1, 2, 1, 2, 4, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0);
      idle(LOCK + 2);
    end
    cmp("pin_win_score1", 32'(score1), WIN);
    cmp("pin_game_over", 32'(game_over), 1);
    cmp("pin_winner", 32'(winner), 0);
    for (int i = 0; i < 20; i++)
      tick(1, 1, 5, 1, 0, i[0], !i[0]);
    cmp("pin_frozen_score1", 32'(score1), WIN);
    cmp("pin_frozen_score2", 32'(score2), 0);
    cmp("pin_frozen_over", 32'(game_over), 1);
    areset();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
